// File: rtl/btn_debounce_multi.sv
// Multi-channel pushbutton conditioner: per channel a 2-FF synchroniser,
// a consecutive-cycle stability filter, and a press FSM producing clean
// level plus press / release / long-press / auto-repeat strobes.
module btn_debounce_multi #(
  parameter int              N_CH         = 4,
  parameter int              DEBOUNCE_CYC = 100000,
  parameter int              DB_W         = 17,
  parameter int              LONG_CYC     = 100000000,
  parameter int              REPEAT_CYC   = 20000000,
  parameter int              HOLD_W       = 27,
  parameter logic [N_CH-1:0] ACTIVE_LOW   = {N_CH{1'b0}},
  parameter int              REPEAT_EN    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] noisy_btn,
  output logic [N_CH-1:0] clean_btn,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Terminal counts: a counter sitting at *_LAST completes its interval on
  // the coming edge, which makes the registered strobe land exactly
  // N cycles after the reference cycle.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic              REP_BIT   = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_s2;

  // Two-stage synchroniser with per-channel polarity correction up front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= {N_CH{1'b0}};
      r_s2 <= {N_CH{1'b0}};
    end else begin
      r_s1 <= noisy_btn ^ ACTIVE_LOW;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [1:0]        r_state;
    logic              r_clean;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              r_repeat;
    logic              w_differ;
    logic              w_db_done;
    logic              w_rise;
    logic              w_fall;

    // The flip events are decoded one edge early so the FSM strobes are
    // registered on the same edge that updates the clean level.
    assign w_differ  = r_s2[g] ^ r_clean;
    assign w_db_done = (r_db_cnt == DB_LAST);
    assign w_rise    = w_differ & w_db_done & r_s2[g];
    assign w_fall    = w_differ & w_db_done & ~r_s2[g];

    // Stability filter: count consecutive disagreeing cycles, any agreeing
    // cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clean  <= 1'b0;
        r_db_cnt <= {DB_W{1'b0}};
      end else if (!w_differ) begin
        r_db_cnt <= {DB_W{1'b0}};
      end else if (w_db_done) begin
        r_clean  <= r_s2[g];
        r_db_cnt <= {DB_W{1'b0}};
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end

    // Press FSM; a release overrides any timer expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_hold_cnt <= {HOLD_W{1'b0}};
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        if (w_fall) begin
          r_release  <= 1'b1;
          r_hold_cnt <= {HOLD_W{1'b0}};
          r_state    <= ST_IDLE;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_press    <= 1'b1;
                r_hold_cnt <= {HOLD_W{1'b0}};
                r_state    <= ST_HELD;
              end else begin
                r_hold_cnt <= {HOLD_W{1'b0}};
              end
            end
            ST_HELD: begin
              if (r_hold_cnt == LONG_LAST) begin
                r_long     <= 1'b1;
                r_hold_cnt <= {HOLD_W{1'b0}};
                r_state    <= ST_REPEAT;
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
              end
            end
            ST_REPEAT: begin
              if (r_hold_cnt == REP_LAST) begin
                r_repeat   <= REP_BIT;
                r_hold_cnt <= {HOLD_W{1'b0}};
              end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
              end
            end
            default: begin
              r_state    <= ST_IDLE;
              r_hold_cnt <= {HOLD_W{1'b0}};
            end
          endcase
        end
      end
    end

    assign clean_btn[g]     = r_clean;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;
    assign long_pulse[g]    = r_long;
    assign repeat_pulse[g]  = r_repeat;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi with short timing parameters.
// Main instance: ACTIVE_LOW=2'b10, repeat enabled. Second instance has
// repeat disabled and is pressed only during the long-press scenario.
module tb_btn_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [1:0] noisy;
  logic [1:0] clean, press, rel, lng, rep;
  logic [1:0] nr_noisy;
  logic [1:0] nr_clean, nr_press, nr_rel, nr_lng, nr_rep;
  int         checks;
  int         errors;

  btn_debounce_multi #(
    .N_CH(2), .DEBOUNCE_CYC(4), .DB_W(17), .LONG_CYC(10), .REPEAT_CYC(3),
    .HOLD_W(27), .ACTIVE_LOW(2'b10), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .noisy_btn(noisy), .clean_btn(clean),
    .press_pulse(press), .release_pulse(rel), .long_pulse(lng),
    .repeat_pulse(rep)
  );

  btn_debounce_multi #(
    .N_CH(2), .DEBOUNCE_CYC(4), .DB_W(17), .LONG_CYC(10), .REPEAT_CYC(3),
    .HOLD_W(27), .ACTIVE_LOW(2'b00), .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .noisy_btn(nr_noisy), .clean_btn(nr_clean),
    .press_pulse(nr_press), .release_pulse(nr_rel), .long_pulse(nr_lng),
    .repeat_pulse(nr_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    noisy    = 2'b10;
    nr_noisy = 2'b00;
    #3;
    checks++;
    if ({clean, press, rel, lng, rep} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b want 0", {clean, press, rel, lng, rep});
      errors++;
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (clean !== 2'b00) begin
      $display("FAIL active_low_idle_clean: got %b want 00", clean);
      errors++;
    end
    checks++;
    if ({press, rel, lng, rep, nr_clean} !== 10'd0) begin
      $display("FAIL idle_quiet: got %b want 0", {press, rel, lng, rep, nr_clean});
      errors++;
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      noisy[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if ({clean, press, rel, lng, rep} !== 10'd0) begin
          $display("FAIL glitch_hi r%0d: got %b want 0", r, {clean, press, rel, lng, rep});
          errors++;
        end
      end
      noisy[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if ({clean, press, rel, lng, rep} !== 10'd0) begin
          $display("FAIL glitch_lo r%0d: got %b want 0", r, {clean, press, rel, lng, rep});
          errors++;
        end
      end
    end
  endtask

  task automatic test_clean_press();
    noisy[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (clean[0] !== (k >= 6) || press !== ((k == 6) ? 2'b01 : 2'b00)) begin
        $display("FAIL press_timing k=%0d: clean=%b press=%b want clean=%0d press0=%0d",
                 k, clean, press, (k >= 6), (k == 6));
        errors++;
      end
    end
    noisy[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (clean[0] !== (k < 6) || rel !== ((k == 6) ? 2'b01 : 2'b00) ||
          {lng, rep} !== 4'd0) begin
        $display("FAIL release_timing k=%0d: clean=%b rel=%b long=%b rep=%b want clean=%0d rel0=%0d",
                 k, clean, rel, lng, rep, (k < 6), (k == 6));
        errors++;
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [3:0] exp_s;
    logic [3:0] exp_nr;
    noisy[0]    = 1'b1;
    nr_noisy[0] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (press !== 2'b01 || nr_press !== 2'b01) begin
      $display("FAIL long_press_start: press=%b nr_press=%b want 01 01", press, nr_press);
      errors++;
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      // {press, release, long, repeat} for channel 0
      exp_s  = {1'b0, (k == 28), (k == 10),
                (k >= 13 && k <= 25 && ((k - 13) % 3) == 0)};
      exp_nr = {1'b0, (k == 28), (k == 10), 1'b0};
      checks++;
      if ({press[0], rel[0], lng[0], rep[0]} !== exp_s ||
          {press[1], rel[1], lng[1], rep[1]} !== 4'b0000) begin
        $display("FAIL long_repeat k=%0d: got p/r/l/rp=%b ch1=%b want %b",
                 k, {press[0], rel[0], lng[0], rep[0]},
                 {press[1], rel[1], lng[1], rep[1]}, exp_s);
        errors++;
      end
      checks++;
      if ({nr_press[0], nr_rel[0], nr_lng[0], nr_rep[0]} !== exp_nr) begin
        $display("FAIL no_repeat_inst k=%0d: got p/r/l/rp=%b want %b",
                 k, {nr_press[0], nr_rel[0], nr_lng[0], nr_rep[0]}, exp_nr);
        errors++;
      end
      if (k == 22) begin
        noisy[0]    = 1'b0;
        nr_noisy[0] = 1'b0;
      end
    end
  endtask

  task automatic test_short_press(input int drop_k);
    noisy[0] = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (press !== 2'b01) begin
      $display("FAIL short_press_start d%0d: press=%b want 01", drop_k, press);
      errors++;
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++;
      if (rel !== ((k == drop_k + 6) ? 2'b01 : 2'b00) || {press, lng, rep} !== 6'd0) begin
        $display("FAIL short_press d%0d k=%0d: rel=%b press=%b long=%b rep=%b want rel0=%0d",
                 drop_k, k, rel, press, lng, rep, (k == drop_k + 6));
        errors++;
      end
      if (k == drop_k) noisy[0] = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    noisy = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (press !== ((k == 6) ? 2'b11 : 2'b00) || clean !== ((k == 6) ? 2'b11 : 2'b00)) begin
        $display("FAIL simul_press k=%0d: press=%b clean=%b want %0d%0d",
                 k, press, clean, (k == 6), (k == 6));
        errors++;
      end
    end
    noisy = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (rel !== ((k == 6) ? 2'b11 : 2'b00) || clean !== ((k == 6) ? 2'b00 : 2'b11)) begin
        $display("FAIL simul_release k=%0d: rel=%b clean=%b", k, rel, clean);
        errors++;
      end
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_mid_repeat();
    noisy = 2'b11;
    for (int k = 0; k < 6; k++) tick();
    for (int k = 0; k < 11; k++) tick();
    checks++;
    if (clean !== 2'b01) begin
      $display("FAIL pre_reset_clean: got %b want 01", clean);
      errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clean, press, rel, lng, rep} !== 10'd0) begin
      $display("FAIL async_reset: got %b want 0", {clean, press, rel, lng, rep});
      errors++;
    end
    tick(); tick();
    checks++;
    if ({clean, press, rel, lng, rep} !== 10'd0) begin
      $display("FAIL reset_hold: got %b want 0", {clean, press, rel, lng, rep});
      errors++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (press !== ((k == 6) ? 2'b01 : 2'b00) || clean !== ((k >= 6) ? 2'b01 : 2'b00) ||
          {rel, lng, rep} !== 6'd0) begin
        $display("FAIL post_reset k=%0d: press=%b clean=%b rel=%b want press0=%0d",
                 k, press, clean, rel, (k == 6));
        errors++;
      end
    end
    noisy = 2'b10;
    for (int k = 0; k < 8; k++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_glitch();
    test_clean_press();
    for (int k = 0; k < 4; k++) tick();
    test_long_repeat();
    for (int k = 0; k < 4; k++) tick();
    test_short_press(1);
    test_short_press(4);
    for (int k = 0; k < 4; k++) tick();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
